// File: rtl/log2_pipe_if.sv
// Sample stream interface for log2_pipe: clock enable, input sample, and
// the log-domain result with its zero-input flag.
interface log2_pipe_if #(
  parameter int IN_W  = 24,
  parameter int OUT_W = 14
);
  logic             ce;
  logic             in_valid;
  logic [IN_W-1:0]  din;
  logic             out_valid;
  logic [OUT_W-1:0] dout;
  logic             zero_flag;

  modport master (
    output ce, in_valid, din,
    input  out_valid, dout, zero_flag
  );

  modport slave (
    input  ce, in_valid, din,
    output out_valid, dout, zero_flag
  );
endinterface

// File: rtl/log2_pipe.sv
// Four-stage pipelined log2 of an unsigned fixed-point sample, producing a
// signed INT_W.OUT_FRAC result using a LUT with linear interpolation.
module log2_pipe #(
  parameter int IN_W     = 24,
  parameter int IN_FRAC  = 8,
  parameter int OUT_FRAC = 8,
  parameter int LUT_AW   = 6,
  parameter int INTERP_W = 6
) (
  input  logic      clk,
  input  logic      reset_n,
  log2_pipe_if.slave bus
);
  localparam int INT_W = $clog2(IN_W) + 1;
  localparam int OUT_W = INT_W + OUT_FRAC;
  localparam int M_W   = $clog2(IN_W);
  localparam int KF_W  = LUT_AW + INTERP_W;
  localparam int LUT_N = (1 << LUT_AW) + 1;
  localparam int L_W   = OUT_FRAC + 1;
  localparam int S_W   = OUT_FRAC + 2;
  localparam int P_W   = L_W + INTERP_W + 1;
  localparam logic [OUT_FRAC-1:0] FRAC_MAX = '1;

  // Table entries are fixed at elaboration; the real math folds to constants.
  function automatic logic [L_W-1:0] lut_val(input int i);
    real r;
    r = $ln(1.0 + real'(i) / real'(1 << LUT_AW)) / $ln(2.0) * real'(1 << OUT_FRAC);
    return L_W'($rtoi(r + 0.5));
  endfunction

  logic [L_W-1:0] lut [LUT_N];
  for (genvar gi = 0; gi < LUT_N; gi++) begin : g_lut
    assign lut[gi] = lut_val(gi);
  end

  logic              v1, v2, v3, ov_q;
  logic [IN_W-1:0]   din1;
  logic [M_W-1:0]    m1;
  logic              zero1, zero2, zero3, zf_q;
  logic [LUT_AW:0]   k2;
  logic [INTERP_W-1:0] f2, f3;
  logic [INT_W-1:0]  e2, e3;
  logic [L_W-1:0]    lo3, hi3;
  logic [OUT_W-1:0]  dout_q;

  logic [M_W-1:0]    msb_c;
  logic [KF_W-1:0]   kf_c;
  logic [L_W-1:0]    diff_c;
  logic [P_W-1:0]    prod_c;
  logic [S_W-1:0]    sum_c;
  logic [OUT_FRAC-1:0] frac_c;
  logic [OUT_W-1:0]  dout_c;

  always_comb begin
    msb_c = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (bus.din[i]) msb_c = M_W'(i);
    end
  end

  // Left-justify under the leading one; the cast drops that one and keeps k,f.
  assign kf_c = KF_W'((din1 << (M_W'(IN_W - 1) - m1)) >> (IN_W - 1 - KF_W));

  assign diff_c = hi3 - lo3;
  assign prod_c = P_W'(diff_c) * P_W'(f3) + P_W'(1 << (INTERP_W - 1));
  assign sum_c  = S_W'(lo3) + S_W'(prod_c >> INTERP_W);
  assign frac_c = (sum_c > S_W'(FRAC_MAX)) ? FRAC_MAX : sum_c[OUT_FRAC-1:0];
  assign dout_c = zero3 ? {1'b1, {(OUT_W-1){1'b0}}} : {e3, frac_c};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0; ov_q <= 1'b0;
      din1 <= '0; m1 <= '0; zero1 <= 1'b0;
      k2 <= '0; f2 <= '0; e2 <= '0; zero2 <= 1'b0;
      lo3 <= '0; hi3 <= '0; f3 <= '0; e3 <= '0; zero3 <= 1'b0;
      dout_q <= '0; zf_q <= 1'b0;
    end else if (bus.ce) begin
      v1    <= bus.in_valid;
      din1  <= bus.din;
      m1    <= msb_c;
      zero1 <= (bus.din == '0);

      v2    <= v1;
      k2    <= (LUT_AW+1)'(kf_c[KF_W-1 -: LUT_AW]);
      f2    <= kf_c[INTERP_W-1:0];
      e2    <= INT_W'(m1) - INT_W'(IN_FRAC);
      zero2 <= zero1;

      v3    <= v2;
      lo3   <= lut[k2];
      hi3   <= lut[k2 + (LUT_AW+1)'(1)];
      f3    <= f2;
      e3    <= e2;
      zero3 <= zero2;

      ov_q  <= v3;
      if (v3) begin
        dout_q <= dout_c;
        zf_q   <= zero3;
      end
    end
  end

  assign bus.out_valid = ov_q;
  assign bus.dout      = dout_q;
  assign bus.zero_flag = zf_q;
endmodule

// File: tb/tb_log2_pipe.sv
// Bench for log2_pipe: directed literals, full low-range sweep, random
// ce/in_valid stream and mid-stream reset, all checked against a queue model.
module tb_log2_pipe;
  localparam int IN_W  = 24;
  localparam int OUT_W = 14;

  logic clk = 1'b0;
  logic reset_n;

  log2_pipe_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();
  log2_pipe dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_out = 0;
  logic sweep_tag = 1'b0;
  logic [IN_W:0] exp_q[$];
  int mono_bad = 0, err_bad = 0, gap_bad = 0, sweep_n = 0;
  logic have_prev = 1'b0;
  int prev_sweep = 0;

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  function automatic int lut_ref(input int i);
    return $rtoi($floor($ln(1.0 + real'(i) / 64.0) / $ln(2.0) * 256.0 + 0.5));
  endfunction

  // Splits a non-zero sample into exponent, table index and interpolation fraction.
  function automatic void split(input logic [IN_W-1:0] d, output int e, output int k, output int f);
    int m;
    longint mant;
    m = 0;
    for (int i = 0; i < IN_W; i++) if (d[i]) m = i;
    e = m - 8;
    mant = (longint'(d) - (longint'(1) << m)) << (23 - m);
    k = int'(mant >> 17);
    f = int'((mant >> 11) & 63);
  endfunction

  // Returns {zero_flag, dout}.
  function automatic logic [OUT_W:0] model(input logic [IN_W-1:0] d);
    int e, k, f, lo, hi, fr, r;
    if (d == '0) return {1'b1, 14'h2000};
    split(d, e, k, f);
    lo = lut_ref(k);
    hi = lut_ref(k + 1);
    fr = lo + ((hi - lo) * f + 32) / 64;
    if (fr > 255) fr = 255;
    r = e * 256 + fr;
    return {1'b0, r[13:0]};
  endfunction

  function automatic real ref_real(input logic [IN_W-1:0] d);
    int e, k, f;
    split(d, e, k, f);
    return (real'(e) + $ln(1.0 + real'(k * 64 + f) / 4096.0) / $ln(2.0)) * 256.0;
  endfunction

  task automatic sweep_props(input logic [IN_W-1:0] d, input logic [OUT_W-1:0] q);
    int cur;
    real err;
    cur = int'($signed(q));
    err = real'(cur) - ref_real(d);
    if (err < 0.0) err = -err;
    if (err > 1.0) err_bad++;
    if (have_prev) begin
      if (cur < prev_sweep) mono_bad++;
      if (d >= 24'h000100 && ((cur >>> 2) - (prev_sweep >>> 2)) > 1) gap_bad++;
    end
    have_prev = 1'b1;
    prev_sweep = cur;
    sweep_n++;
  endtask

  initial begin : cmp
    logic rs, cs, vs, tg;
    logic [IN_W-1:0] ds;
    logic [OUT_W+1:0] prev_o, cur_o;
    logic [IN_W:0] ent;
    prev_o = '0;
    forever begin
      @(posedge clk);
      rs = reset_n; cs = bus.ce; vs = bus.in_valid; ds = bus.din; tg = sweep_tag;
      #1;
      cur_o = {bus.out_valid, bus.zero_flag, bus.dout};
      if (!rs) begin
        exp_q.delete();
        check("reset_outputs", cur_o, 0);
      end else if (!cs) begin
        check("hold_ce_low", cur_o, prev_o);
      end else begin
        if (bus.out_valid) begin
          n_out++;
          check("out_has_pending_sample", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            ent = exp_q.pop_front();
            check("model_dout", {bus.zero_flag, bus.dout}, model(ent[IN_W-1:0]));
            if (ent[IN_W]) sweep_props(ent[IN_W-1:0], bus.dout);
          end
        end
        if (vs) exp_q.push_back({tg, ds});
      end
      prev_o = cur_o;
    end
  end

  task automatic drive(input logic v, input logic [IN_W-1:0] d, input logic c);
    @(negedge clk);
    bus.in_valid = v;
    bus.din = d;
    bus.ce = c;
  endtask

  task automatic directed(input string name, input logic [IN_W-1:0] d, input logic [OUT_W:0] req);
    check({"model_", name}, model(d), req);
    drive(1'b1, d, 1'b1);
    drive(1'b0, '0, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1 check({"early_", name}, bus.out_valid, 0);
    @(posedge clk);
    #1;
    check({"lat4_valid_", name}, bus.out_valid, 1);
    check({"lat4_", name}, {bus.zero_flag, bus.dout}, req);
  endtask

  function automatic logic [IN_W-1:0] rand_din();
    int sh;
    logic [31:0] r;
    sh = $urandom_range(0, IN_W - 1);
    r = $urandom & ((32'd1 << (sh + 1)) - 32'd1);
    if ($urandom_range(0, 15) == 0) r = '0;
    return r[IN_W-1:0];
  endfunction

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin : stim
    int acc, base;
    logic c, v;
    reset_n = 1'b0;
    bus.ce = 1'b0;
    bus.in_valid = 1'b0;
    bus.din = '0;
    repeat (3) @(negedge clk);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_dout", bus.dout, 0);
    check("reset_zero_flag", bus.zero_flag, 0);
    reset_n = 1'b1;
    bus.ce = 1'b1;
    repeat (2) drive(1'b0, '0, 1'b1);

    directed("pow_1p0",  24'h000100, 15'h0000);
    directed("pow_2p0",  24'h000200, 15'h0100);
    directed("pow_0p5",  24'h000080, 15'h3F00);
    directed("pow_lsb",  24'h000001, 15'h3800);
    directed("interp_3", 24'h000300, 15'h0196);
    directed("sat_max",  24'hFFFFFF, 15'h0FFF);
    directed("interp_1p5", 24'h000180, 15'h0096);
    directed("zero_in",  24'h000000, 15'h6000);
    directed("after_zero", 24'h000100, 15'h0000);

    sweep_tag = 1'b1;
    for (int d = 1; d <= 32'h0000FFFF; d++) drive(1'b1, d[IN_W-1:0], 1'b1);
    drive(1'b0, '0, 1'b1);
    sweep_tag = 1'b0;
    repeat (6) drive(1'b0, '0, 1'b1);
    check("sweep_count", sweep_n, 65535);
    check("sweep_monotonic_viol", mono_bad, 0);
    check("sweep_err_over_1lsb", err_bad, 0);
    check("sweep_code_gaps", gap_bad, 0);

    base = n_out;
    acc = 0;
    while (acc < 1000) begin
      c = ($urandom_range(0, 3) != 0);
      v = ($urandom_range(0, 2) != 0);
      drive(v, rand_din(), c);
      if (c && v) acc++;
    end
    repeat (6) drive(1'b0, '0, 1'b1);
    check("rand_out_count", n_out - base, 1000);
    check("rand_queue_empty", exp_q.size(), 0);

    drive(1'b1, 24'h000100, 1'b1);
    drive(1'b1, 24'h000200, 1'b1);
    drive(1'b1, 24'h000300, 1'b1);
    @(negedge clk);
    reset_n = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1 check("rst_clear", {bus.out_valid, bus.zero_flag, bus.dout}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    bus.in_valid = 1'b1;
    bus.din = 24'h000200;
    bus.ce = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1 check("rst_no_stale_valid", bus.out_valid, 0);
    end
    @(posedge clk);
    #1;
    check("rst_first_valid", bus.out_valid, 1);
    check("rst_first_dout", {bus.zero_flag, bus.dout}, 15'h0100);
    repeat (6) drive(1'b0, '0, 1'b1);
    check("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/log2_pipe.md
# log2_pipe

Parametrised, pipelined base-2 logarithm for the discrete-audio math library. It is the successor to the fixed 24-in/12-out log block and adds four things: signed output so inputs below 1.0 are handled, linear interpolation between LUT entries so there are no missing output codes, a valid/clock-enable pipeline, and a zero-input flag. It feeds gain and envelope stages that work in the log domain.

## Interface
- IN_W, 24: unsigned input width.
- IN_FRAC, 8: binary-point position of the input (input = din / 2^IN_FRAC). Range 0 ≤ IN_FRAC < IN_W.
- OUT_FRAC, 8: number of fraction bits in the output.
- LUT_AW, 6: LUT address bits. The LUT has 2^LUT_AW+1 entries.
- INTERP_W, 6: interpolation fraction bits.
- Derived: INT_W = $clog2(IN_W)+1 and OUT_W = INT_W+OUT_FRAC (14 at defaults).
- clk, input, 1: clock. One clock domain.
- reset_n, input, 1: synchronous, active-low reset.
- ce, input, 1: clock enable. When low, every pipeline register holds.
- in_valid, input, 1: din is valid this cycle.
- din, input, IN_W: unsigned fixed-point input.
- out_valid, output, 1: dout and zero_flag are valid.
- dout, output, OUT_W: signed two's complement log2(din/2^IN_FRAC), format INT_W.OUT_FRAC.
- zero_flag, output, 1: the sample had din == 0.

## Operation
- **Stage 1:** priority-encode din to get the MSB index m (0..IN_W-1). Register din, m, in_valid, and zero = (din == 0).
- **Stage 2:** barrel-shift to remove the leading one and left-justify the remaining m bits into an (IN_W-1)-bit mantissa. Missing low bits are zero-filled.
  - k = top LUT_AW mantissa bits.
  - f = next INTERP_W bits.
  - Integer part e = m − IN_FRAC, signed INT_W bits (−IN_FRAC..IN_W−1−IN_FRAC).
- **Stage 3:** read L[k] and L[k+1] and register them.
  - L[i] = round(log2(1 + i/2^LUT_AW) · 2^OUT_FRAC). L[0] = 0 and L[2^LUT_AW] = 2^OUT_FRAC.
  - Contents are computed at elaboration.
- **Stage 4:** frac = L[k] + (((L[k+1]−L[k])·f + 2^(INTERP_W−1)) >> INTERP_W), unsigned.
  - Saturate frac to 2^OUT_FRAC−1.
  - dout = {e, frac[OUT_FRAC−1:0]}, i.e. e·2^OUT_FRAC + frac.
- **Zero input:** dout = most negative OUT_W value (1 followed by zeros) and zero_flag = 1.
- **Non-zero input:** zero_flag = 0.
- dout and zero_flag update only when ce = 1 and the stage-4 valid bit is 1. Otherwise they hold their last value.
- in_valid low inserts a bubble: the valid bit propagates as 0 and data registers may load freely.
- No backpressure beyond ce. Every enabled cycle accepts a new sample.

## Timing
- Latency is 4 enabled cycles from in_valid/din to out_valid/dout. Throughput is 1 sample per enabled cycle.
- With ce low for N cycles, the output appears 4+N cycles later, with no sample loss or duplication.
- out_valid is high for exactly one enabled cycle per accepted sample. It stays stable while ce is low.
- Reset values: all valid bits 0, out_valid 0, dout 0, zero_flag 0. Data registers are cleared.
- Reset takes priority over ce. A reset issued mid-stream discards all in-flight samples: no out_valid for them afterwards.
- The first sample accepted in the cycle reset_n returns high emerges 4 cycles later.

## Test plan
- **Exact powers** (defaults, ce=1):
  - din 0x000100 → dout 0x0000.
  - din 0x000200 → dout 0x0100.
  - din 0x000080 → dout 0x3F00 (−1.0).
  - din 0x000001 → dout 0x3800 (−8.0).
  - zero_flag 0 for all; each result 4 cycles after input.
- **Interpolation and saturation:**
  - din 0x000300 → dout 0x0196 (1.5859).
  - din 0xFFFFFF → dout 0x0FFF (frac saturated).
  - din 0x000180 → dout 0x0096.
- **Zero input:** din 0 → dout 0x2000, zero_flag 1. The next sample, 0x000100, returns zero_flag 0.
- **Monotonic sweep:** din 0x000001..0x00FFFF stepping 1, compared against a real-valued model. |error| ≤ 1 LSB, output non-decreasing, no missing codes in the upper 12 bits.
- **Stall and bubbles:** random in_valid and ce patterns over 1000 samples. The out_valid count equals the accepted count, order is preserved, and dout holds while ce=0.
- **Reset:** drop reset_n for 1 cycle with 3 samples in flight.
  - Outputs go to 0 the next cycle and no stale out_valid appears.
  - A sample accepted right after reset appears at exactly 4 cycles.
